// File: rtl/motor_pkg.sv
// Shared types and defaults for the H-bridge gate controller.
// States, default dead-time and reversal wait, and small helpers.
package motor_pkg;

  typedef enum logic [2:0] {
    ST_COAST,
    ST_FWD,
    ST_REV,
    ST_BRAKE,
    ST_DEAD,
    ST_SWITCH
  } state_t;

  localparam int DEAD_CYCLES_DEF  = 8;
  localparam int REVERSE_WAIT_DEF = 64;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // A direct FWD<->REV swap needs the long wait so the motor can spin down.
  function automatic logic is_reversal(state_t from, state_t to);
    return ((from == ST_FWD) && (to == ST_REV)) ||
           ((from == ST_REV) && (to == ST_FWD));
  endfunction

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: complementary hi/lo drive with dead time inserted
// on every level change, so hi and lo are never on together.
module deadtime_leg import motor_pkg::*; #(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int CNT_W       = $clog2(DEAD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic level,
  output logic hi,
  output logic lo
);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("deadtime_leg: DEAD_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD_CYCLES);

  logic             was_active;
  logic             last;
  logic [CNT_W-1:0] stable;
  logic [CNT_W-1:0] stable_nxt;

  // stable counts consecutive edges the requested level has held. Coming out
  // of an inactive period the leg has already been off long enough, so it is
  // treated as fully settled and may switch on at once.
  always_comb begin
    stable_nxt = DEAD_C;
    if (was_active) begin
      if (level != last)        stable_nxt = '0;
      else if (stable < DEAD_C) stable_nxt = stable + CNT_W'(1);
      else                      stable_nxt = stable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= 1'b0;
      lo         <= 1'b0;
      was_active <= 1'b0;
      last       <= 1'b0;
      stable     <= '0;
    end else begin
      was_active <= active;
      last       <= level;
      stable     <= stable_nxt;
      hi         <= active &&  level && (stable_nxt >= DEAD_C);
      lo         <= active && !level && (stable_nxt >= DEAD_C);
    end
  end

endmodule

// File: rtl/motor_bridge_ctrl.sv
// Full H-bridge controller: picks coast/forward/reverse/brake and sequences
// every change through an all-off dead or reversal window.
module motor_bridge_ctrl import motor_pkg::*; #(
  parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF,
  parameter int REVERSE_WAIT = REVERSE_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic run,
  input  logic dir,
  input  logic brake,
  output logic ah,
  output logic al,
  output logic bh,
  output logic bl,
  output logic busy
);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("motor_bridge_ctrl: DEAD_CYCLES must be at least 1");
  end

  localparam int CNT_MAX = max2(DEAD_CYCLES, REVERSE_WAIT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD_CYCLES);
  localparam logic [CW-1:0] REV_C   = CW'(REVERSE_WAIT);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

  state_t        state, state_nxt;
  state_t        tgt, tgt_nxt;
  state_t        orig, orig_nxt;
  state_t        target;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] wait_len;
  logic          leg_on;
  logic          level_a;
  logic          level_b;

  always_comb begin
    target    = brake ? ST_BRAKE : (!run ? ST_COAST : (dir ? ST_REV : ST_FWD));
    state_nxt = state;
    tgt_nxt   = tgt;
    orig_nxt  = orig;
    cnt_nxt   = cnt;
    wait_len  = (state == ST_SWITCH) ? REV_C : DEAD_C;
    unique case (state)
      ST_DEAD, ST_SWITCH: begin
        // A new target restarts the window; its length depends on where we
        // came from, so returning to the origin only costs the dead time.
        if (target != tgt) begin
          tgt_nxt   = target;
          cnt_nxt   = CW'(1);
          state_nxt = is_reversal(orig, target) ? ST_SWITCH : ST_DEAD;
        end else if (cnt >= wait_len) begin
          state_nxt = tgt;
          cnt_nxt   = '0;
        end else if (cnt < CNT_SAT) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        if (target != state) begin
          tgt_nxt   = target;
          orig_nxt  = state;
          cnt_nxt   = CW'(1);
          state_nxt = is_reversal(state, target) ? ST_SWITCH : ST_DEAD;
        end
      end
    endcase
  end

  // Legs follow the state being entered this edge so gates switch with it.
  always_comb begin
    leg_on  = (state_nxt == ST_FWD) || (state_nxt == ST_REV) ||
              (state_nxt == ST_BRAKE);
    level_a = (state_nxt == ST_FWD) && en;
    level_b = (state_nxt == ST_REV) && en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_COAST;
      tgt   <= ST_COAST;
      orig  <= ST_COAST;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      orig  <= orig_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_DEAD) || (state_nxt == ST_SWITCH);
    end
  end

  deadtime_leg #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CW)
  ) u_leg_a (
    .clk    (clk),
    .reset  (reset),
    .active (leg_on),
    .level  (level_a),
    .hi     (ah),
    .lo     (al)
  );

  deadtime_leg #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CW)
  ) u_leg_b (
    .clk    (clk),
    .reset  (reset),
    .active (leg_on),
    .level  (level_b),
    .hi     (bh),
    .lo     (bl)
  );

endmodule
